cr_huf_comp_lut_pp_ctrl: RTL and testbench
==========================================

Name: cr_huf_comp_lut_pp_ctrl

Overview:
- Ping-pong scheduler for the two-bank long-symbol LUT pair: LUT bank 0 and LUT bank 1.
- Allocates the next free bank to a new frame.
- Tracks completion of the Huffman-weight (hw) and symbol-table (st) writes into that bank.
- Presents filled banks to the symbol assembler (sa) strictly in allocation order, and frees each bank on sa return-ack.
- Its outputs drive the bank-select, write-enable steering and full flags of the LUT pair.

Parameters:
- SEQID_W, 4, width of frame sequence id carried with each allocation.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- alloc_req  in  1  new-frame bank request; held until granted.
- alloc_seq_id  in  SEQID_W  sequence id of requesting frame.
- alloc_gnt  out  1  grant; a transfer occurs when alloc_req & alloc_gnt.
- alloc_bank  out  1  bank granted; valid with alloc_gnt.
- hw_wr_done  in  1  hw writer finished filling a bank (1-cycle pulse).
- hw_wr_bank  in  1  bank targeted by hw_wr_done.
- st_wr_done  in  1  st writer finished filling a bank (1-cycle pulse).
- st_wr_bank  in  1  bank targeted by st_wr_done.
- sa_rd_vld  out  1  head bank is ready for sa reads.
- sa_rd_bank  out  1  head bank index.
- sa_rd_seq_id  out  SEQID_W  seq id stored for head bank.
- sa_ret_ack  in  1  sa done with head bank; releases it.
- bank_state  out  4  {bank1[1:0], bank0[1:0]}: 0=IDLE, 1=FILL, 2=READY.
- lut_full  out  1  both banks not IDLE.
- err_proto  out  1  1-cycle pulse on protocol violation.

Behaviour:
- Per-bank state register: IDLE/FILL/READY, plus hw_seen, st_seen flags and a SEQID_W seq register.
- Pointers: wp (next bank to allocate) and rp (next bank to read), both 1 bit. Occupancy counter cnt is 2 bits, range 0..2.
- Reset (rst_n=0 at clk edge), including mid-operation:
  - All banks IDLE; flags and seq registers 0; wp=rp=0; cnt=0.
  - Outputs alloc_gnt=0, sa_rd_vld=0, sa_rd_bank=0, sa_rd_seq_id=0, lut_full=0, bank_state=0, err_proto=0.
  - In-flight done pulses and acks are discarded.
- Allocation:
  - alloc_gnt = rst_n & state[wp]==IDLE; combinational; alloc_bank = wp. Zero-cycle grant.
  - On transfer: state[wp]<=FILL, seq[wp]<=alloc_seq_id, flags cleared, wp toggles, cnt+1.
- Fill:
  - hw_wr_done sets hw_seen[hw_wr_bank]; st_wr_done sets st_seen[st_wr_bank]. Either order, or the same cycle.
  - A bank moves FILL->READY on the edge where both flags are (or become) set. Minimum done-to-ready latency is 1 cycle.
  - Done to a bank not in FILL, or a repeat done while its flag is already set: ignored, err_proto pulse next cycle.
  - Both dones may target different banks in the same cycle; each is handled independently.
- Read:
  - sa_rd_vld = state[rp]==READY (registered state, no extra flop); sa_rd_bank = rp; sa_rd_seq_id = seq[rp].
  - Bank 1 READY while bank 0 (rp) is still in FILL: sa_rd_vld stays 0. Order is never bypassed.
  - sa_ret_ack with sa_rd_vld=1: state[rp]<=IDLE, rp toggles, cnt-1.
  - sa_ret_ack with sa_rd_vld=0: ignored, err_proto pulse.
- Simultaneous events:
  - Ack and allocation in the same cycle: both are applied and cnt is unchanged. Allocation only sees banks IDLE at that edge, so a bank freed by an ack is grantable 1 cycle later.
  - Done and ack targeting the same bank cannot be legal (ack requires READY); the done is flagged as an error.
- lut_full = cnt==2, registered. alloc_gnt=0 whenever lut_full=1. cnt never wraps; all pointer toggles are modulo 2.
- err_proto is a registered 1-cycle pulse (OR of all violation sources); it does not alter state.

Test Plan:
1. Basic flow: reset, alloc_req with seq 5.
   - Required: gnt same cycle, bank 0.
   - hw_wr_done(b0) at t, st_wr_done(b0) at t+3 -> sa_rd_vld=1 at t+4, sa_rd_bank=0, sa_rd_seq_id=5.
   - Ack -> sa_rd_vld=0 next cycle, bank_state=0.
2. Ping-pong / full: allocate seq 1 then seq 2 back-to-back.
   - Required: banks 0 and 1 granted, lut_full=1, third alloc_req sees gnt=0.
   - Fill both, ack bank 0 -> gnt for the third request 1 cycle later, on bank 0.
3. In-order read: fill bank 1 first, then bank 0 5 cycles later.
   - Required: sa_rd_vld stays 0 until bank 0 is READY; it then reports bank 0, then bank 1 after the ack.
4. Same-cycle dones: hw_wr_done and st_wr_done for bank 0 in one cycle.
   - Required: READY next cycle.
   - Separately, hw done to b0 and st done to b1 in the same cycle -> each flag is set independently.
5. Errors:
   - st_wr_done to an IDLE bank -> err_proto 1 pulse, bank_state unchanged.
   - sa_ret_ack with sa_rd_vld=0 -> err_proto pulse, rp unchanged.
   - Duplicate hw_wr_done -> err_proto pulse.
6. Reset mid-operation: bank 0 READY, bank 1 FILL, assert rst_n=0 for 1 cycle.
   - Required: all outputs 0, next alloc granted on bank 0.
   - A stale st_wr_done after reset -> err_proto pulse.

Source files
------------

// File: rtl/cr_huf_comp_lut_pp_ctrl_if.sv
// Bus bundle between the long-symbol LUT ping-pong controller and its
// clients: frame allocator, hw/st writers and the symbol assembler.
// The slave modport is the controller's view; master is the client side.
interface cr_huf_comp_lut_pp_ctrl_if #(
    parameter int SEQID_W = 4
);
    logic               alloc_req;
    logic [SEQID_W-1:0] alloc_seq_id;
    logic               alloc_gnt;
    logic               alloc_bank;
    logic               hw_wr_done;
    logic               hw_wr_bank;
    logic               st_wr_done;
    logic               st_wr_bank;
    logic               sa_rd_vld;
    logic               sa_rd_bank;
    logic [SEQID_W-1:0] sa_rd_seq_id;
    logic               sa_ret_ack;
    logic [3:0]         bank_state;
    logic               lut_full;
    logic               err_proto;

    modport slave (
        input  alloc_req, alloc_seq_id, hw_wr_done, hw_wr_bank,
               st_wr_done, st_wr_bank, sa_ret_ack,
        output alloc_gnt, alloc_bank, sa_rd_vld, sa_rd_bank, sa_rd_seq_id,
               bank_state, lut_full, err_proto
    );

    modport master (
        output alloc_req, alloc_seq_id, hw_wr_done, hw_wr_bank,
               st_wr_done, st_wr_bank, sa_ret_ack,
        input  alloc_gnt, alloc_bank, sa_rd_vld, sa_rd_bank, sa_rd_seq_id,
               bank_state, lut_full, err_proto
    );
endinterface

// File: rtl/cr_huf_comp_lut_pp_ctrl.sv
// Ping-pong scheduler for the two-bank long-symbol LUT pair. Banks are
// handed out in round-robin order, marked READY once both the hw and st
// writers report completion, and presented to the symbol assembler strictly
// in allocation order. Protocol slips raise a one-cycle err_proto pulse
// without disturbing state.
module cr_huf_comp_lut_pp_ctrl #(
    parameter int SEQID_W = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cr_huf_comp_lut_pp_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2
    } bank_st_e;

    bank_st_e           r_state     [2];
    bank_st_e           w_state_nxt [2];
    logic [SEQID_W-1:0] r_seq       [2];
    logic [SEQID_W-1:0] w_seq_nxt   [2];
    logic [1:0]         r_hw_seen, w_hw_nxt;
    logic [1:0]         r_st_seen, w_st_nxt;
    logic               r_wp, r_rp;
    logic [1:0]         r_cnt, w_cnt_nxt;
    logic               r_err, w_err_nxt;

    logic               w_alloc_gnt;
    logic               w_alloc_xfer;
    logic               w_ack_ok;
    logic [1:0]         w_hw_sel;
    logic [1:0]         w_st_sel;

    // Grant is combinational: only a bank already IDLE at this edge is offered.
    assign w_alloc_gnt  = rst_n & (r_state[r_wp] == ST_IDLE);
    assign w_alloc_xfer = bus.alloc_req & w_alloc_gnt;
    assign w_ack_ok     = bus.sa_ret_ack & (r_state[r_rp] == ST_READY);
    assign w_hw_sel     = {bus.hw_wr_done & bus.hw_wr_bank, bus.hw_wr_done & ~bus.hw_wr_bank};
    assign w_st_sel     = {bus.st_wr_done & bus.st_wr_bank, bus.st_wr_done & ~bus.st_wr_bank};

    assign bus.alloc_gnt    = w_alloc_gnt;
    assign bus.alloc_bank   = r_wp;
    assign bus.sa_rd_vld    = (r_state[r_rp] == ST_READY);
    assign bus.sa_rd_bank   = r_rp;
    assign bus.sa_rd_seq_id = r_seq[r_rp];
    assign bus.bank_state   = {r_state[1], r_state[0]};
    assign bus.lut_full     = (r_cnt == 2'd2);
    assign bus.err_proto    = r_err;

    // Next-state for each bank plus protocol-violation detection.
    always_comb begin
        w_err_nxt = bus.sa_ret_ack & ~w_ack_ok;
        w_hw_nxt  = r_hw_seen;
        w_st_nxt  = r_st_seen;
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            w_seq_nxt[b]   = r_seq[b];
            // A done is legal only once per fill, and only while the bank is filling.
            if (w_hw_sel[b]) begin
                if ((r_state[b] == ST_FILL) && !r_hw_seen[b]) begin
                    w_hw_nxt[b] = 1'b1;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end else begin
                w_hw_nxt[b] = r_hw_seen[b];
            end
            if (w_st_sel[b]) begin
                if ((r_state[b] == ST_FILL) && !r_st_seen[b]) begin
                    w_st_nxt[b] = 1'b1;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end else begin
                w_st_nxt[b] = r_st_seen[b];
            end
            case (r_state[b])
                ST_IDLE: begin
                    if (w_alloc_xfer && (r_wp == b[0])) begin
                        w_state_nxt[b] = ST_FILL;
                        w_seq_nxt[b]   = bus.alloc_seq_id;
                        w_hw_nxt[b]    = 1'b0;
                        w_st_nxt[b]    = 1'b0;
                    end else begin
                        w_state_nxt[b] = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (w_hw_nxt[b] && w_st_nxt[b]) begin
                        w_state_nxt[b] = ST_READY;
                    end else begin
                        w_state_nxt[b] = ST_FILL;
                    end
                end
                ST_READY: begin
                    if (w_ack_ok && (r_rp == b[0])) begin
                        w_state_nxt[b] = ST_IDLE;
                    end else begin
                        w_state_nxt[b] = ST_READY;
                    end
                end
                default: w_state_nxt[b] = ST_IDLE;
            endcase
        end
    end

    // Occupancy: an allocation and an ack in the same cycle cancel out.
    always_comb begin
        case ({w_alloc_xfer, w_ack_ok})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // State registers; synchronous reset discards any in-flight dones/acks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state[0] <= ST_IDLE;
            r_state[1] <= ST_IDLE;
            r_seq[0]   <= {SEQID_W{1'b0}};
            r_seq[1]   <= {SEQID_W{1'b0}};
            r_hw_seen  <= 2'b00;
            r_st_seen  <= 2'b00;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_cnt      <= 2'd0;
            r_err      <= 1'b0;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
            r_seq[0]   <= w_seq_nxt[0];
            r_seq[1]   <= w_seq_nxt[1];
            r_hw_seen  <= w_hw_nxt;
            r_st_seen  <= w_st_nxt;
            r_wp       <= r_wp ^ w_alloc_xfer;
            r_rp       <= r_rp ^ w_ack_ok;
            r_cnt      <= w_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_cr_huf_comp_lut_pp_ctrl.sv
// Directed bench for the LUT ping-pong controller. Inputs change 1 time unit
// after the rising edge; outputs are checked at that point, after settling.
module tb_cr_huf_comp_lut_pp_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    cr_huf_comp_lut_pp_ctrl_if #(.SEQID_W(4)) u_if ();

    cr_huf_comp_lut_pp_ctrl #(.SEQID_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then drop every single-cycle input.
    task automatic cyc();
        @(posedge clk);
        #1;
        u_if.alloc_req  = 1'b0;
        u_if.hw_wr_done = 1'b0;
        u_if.st_wr_done = 1'b0;
        u_if.sa_ret_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic alloc(input logic [3:0] seq, input logic exp_bank, input string tag);
        u_if.alloc_req    = 1'b1;
        u_if.alloc_seq_id = seq;
        #1;
        chk({tag, "_gnt"}, 32'(u_if.alloc_gnt), 32'd1);
        chk({tag, "_bank"}, 32'(u_if.alloc_bank), 32'(exp_bank));
        cyc();
    endtask

    task automatic hw(input logic bank);
        u_if.hw_wr_done = 1'b1;
        u_if.hw_wr_bank = bank;
    endtask

    task automatic st(input logic bank);
        u_if.st_wr_done = 1'b1;
        u_if.st_wr_bank = bank;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        u_if.alloc_req    = 1'b0;
        u_if.alloc_seq_id = 4'd0;
        u_if.hw_wr_done   = 1'b0;
        u_if.hw_wr_bank   = 1'b0;
        u_if.st_wr_done   = 1'b0;
        u_if.st_wr_bank   = 1'b0;
        u_if.sa_ret_ack   = 1'b0;

        // 1: reset state and basic flow
        do_reset();
        chk("rst_bank_state", 32'(u_if.bank_state), 32'd0);
        chk("rst_vld", 32'(u_if.sa_rd_vld), 32'd0);
        chk("rst_full", 32'(u_if.lut_full), 32'd0);
        chk("rst_err", 32'(u_if.err_proto), 32'd0);
        alloc(4'd5, 1'b0, "t1_alloc");
        chk("t1_bs_fill", 32'(u_if.bank_state), 32'h1);
        hw(1'b0);
        cyc();
        chk("t1_vld_hw_only", 32'(u_if.sa_rd_vld), 32'd0);
        cyc();
        cyc();
        st(1'b0);
        cyc();
        chk("t1_vld", 32'(u_if.sa_rd_vld), 32'd1);
        chk("t1_rd_bank", 32'(u_if.sa_rd_bank), 32'd0);
        chk("t1_seq", 32'(u_if.sa_rd_seq_id), 32'd5);
        chk("t1_err", 32'(u_if.err_proto), 32'd0);
        u_if.sa_ret_ack = 1'b1;
        cyc();
        chk("t1_vld_after_ack", 32'(u_if.sa_rd_vld), 32'd0);
        chk("t1_bs_after_ack", 32'(u_if.bank_state), 32'd0);

        // 2: ping-pong and full
        do_reset();
        alloc(4'd1, 1'b0, "t2_a1");
        alloc(4'd2, 1'b1, "t2_a2");
        chk("t2_full", 32'(u_if.lut_full), 32'd1);
        chk("t2_bs", 32'(u_if.bank_state), 32'h5);
        u_if.alloc_req = 1'b1; u_if.alloc_seq_id = 4'd3;
        #1;
        chk("t2_gnt_full", 32'(u_if.alloc_gnt), 32'd0);
        hw(1'b0); st(1'b0);
        cyc();
        u_if.alloc_req = 1'b1;
        hw(1'b1); st(1'b1);
        cyc();
        chk("t2_bs_ready", 32'(u_if.bank_state), 32'hA);
        chk("t2_seq_head", 32'(u_if.sa_rd_seq_id), 32'd1);
        u_if.alloc_req = 1'b1;
        u_if.sa_ret_ack = 1'b1;
        #1;
        chk("t2_gnt_ack_cycle", 32'(u_if.alloc_gnt), 32'd0);
        cyc();
        u_if.alloc_req = 1'b1;
        #1;
        chk("t2_gnt_after_ack", 32'(u_if.alloc_gnt), 32'd1);
        chk("t2_bank_after_ack", 32'(u_if.alloc_bank), 32'd0);
        chk("t2_full_after_ack", 32'(u_if.lut_full), 32'd0);
        chk("t2_head_bank1", 32'(u_if.sa_rd_bank), 32'd1);
        cyc();
        chk("t2_bs_realloc", 32'(u_if.bank_state), 32'h9);
        chk("t2_full_again", 32'(u_if.lut_full), 32'd1);

        // 3: in-order read
        do_reset();
        alloc(4'd7, 1'b0, "t3_a1");
        alloc(4'd8, 1'b1, "t3_a2");
        hw(1'b1); st(1'b1);
        cyc();
        chk("t3_bs_b1_ready", 32'(u_if.bank_state), 32'h9);
        chk("t3_vld_blocked", 32'(u_if.sa_rd_vld), 32'd0);
        for (int i = 0; i < 4; i++) cyc();
        chk("t3_vld_still_blocked", 32'(u_if.sa_rd_vld), 32'd0);
        hw(1'b0); st(1'b0);
        cyc();
        chk("t3_vld_b0", 32'(u_if.sa_rd_vld), 32'd1);
        chk("t3_bank_b0", 32'(u_if.sa_rd_bank), 32'd0);
        chk("t3_seq_b0", 32'(u_if.sa_rd_seq_id), 32'd7);
        u_if.sa_ret_ack = 1'b1;
        cyc();
        chk("t3_vld_b1", 32'(u_if.sa_rd_vld), 32'd1);
        chk("t3_bank_b1", 32'(u_if.sa_rd_bank), 32'd1);
        chk("t3_seq_b1", 32'(u_if.sa_rd_seq_id), 32'd8);
        u_if.sa_ret_ack = 1'b1;
        cyc();
        chk("t3_bs_empty", 32'(u_if.bank_state), 32'd0);

        // 4: same-cycle dones
        do_reset();
        alloc(4'd3, 1'b0, "t4_a1");
        alloc(4'd4, 1'b1, "t4_a2");
        hw(1'b0); st(1'b0);
        cyc();
        chk("t4_same_bank_ready", 32'(u_if.bank_state), 32'h6);
        chk("t4_same_bank_err", 32'(u_if.err_proto), 32'd0);
        do_reset();
        alloc(4'd3, 1'b0, "t4_a3");
        alloc(4'd4, 1'b1, "t4_a4");
        hw(1'b0); st(1'b1);
        cyc();
        chk("t4_split_half", 32'(u_if.bank_state), 32'h5);
        chk("t4_split_err", 32'(u_if.err_proto), 32'd0);
        st(1'b0); hw(1'b1);
        cyc();
        chk("t4_split_ready", 32'(u_if.bank_state), 32'hA);
        chk("t4_split_err2", 32'(u_if.err_proto), 32'd0);

        // 5: protocol errors
        do_reset();
        st(1'b0);
        cyc();
        chk("t5_idle_done_err", 32'(u_if.err_proto), 32'd1);
        chk("t5_idle_done_bs", 32'(u_if.bank_state), 32'd0);
        cyc();
        chk("t5_err_pulse_end", 32'(u_if.err_proto), 32'd0);
        u_if.sa_ret_ack = 1'b1;
        cyc();
        chk("t5_ack_err", 32'(u_if.err_proto), 32'd1);
        cyc();
        alloc(4'd9, 1'b0, "t5_a1");
        hw(1'b0);
        cyc();
        chk("t5_first_hw_err", 32'(u_if.err_proto), 32'd0);
        hw(1'b0);
        cyc();
        chk("t5_dup_hw_err", 32'(u_if.err_proto), 32'd1);
        chk("t5_dup_hw_bs", 32'(u_if.bank_state), 32'h1);
        st(1'b0);
        cyc();
        chk("t5_vld", 32'(u_if.sa_rd_vld), 32'd1);
        chk("t5_rp_unchanged", 32'(u_if.sa_rd_bank), 32'd0);
        chk("t5_seq", 32'(u_if.sa_rd_seq_id), 32'd9);

        // 6: reset mid-operation
        do_reset();
        alloc(4'd1, 1'b0, "t6_a1");
        alloc(4'd2, 1'b1, "t6_a2");
        hw(1'b0); st(1'b0);
        cyc();
        hw(1'b1);
        cyc();
        chk("t6_pre_bs", 32'(u_if.bank_state), 32'h6);
        rst_n = 1'b0;
        st(1'b1);
        u_if.sa_ret_ack = 1'b1;
        #1;
        chk("t6_gnt_in_rst", 32'(u_if.alloc_gnt), 32'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("t6_bs", 32'(u_if.bank_state), 32'd0);
        chk("t6_vld", 32'(u_if.sa_rd_vld), 32'd0);
        chk("t6_rd_bank", 32'(u_if.sa_rd_bank), 32'd0);
        chk("t6_rd_seq", 32'(u_if.sa_rd_seq_id), 32'd0);
        chk("t6_full", 32'(u_if.lut_full), 32'd0);
        chk("t6_err", 32'(u_if.err_proto), 32'd0);
        st(1'b0);
        cyc();
        chk("t6_stale_st_err", 32'(u_if.err_proto), 32'd1);
        alloc(4'd6, 1'b0, "t6_a3");
        chk("t6_bs_after", 32'(u_if.bank_state), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
